// File: rtl/gb_cart_bus_cycle.sv
// Game Boy cartridge bus sequencer: one request becomes a SETUP/STROBE/HOLD pin cycle; completion pulses
// SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles after accept, and req_ready stays low until the cycle finishes.
module gb_cart_bus_cycle #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 6,
  parameter int HOLD_CYC   = 1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic        req_sram,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        cart_clk,
  output logic        cart_rd_n,
  output logic        cart_wr_n,
  output logic        cart_cs_n,
  output logic [15:0] cart_addr,
  output logic [7:0]  cart_dout,
  output logic        cart_doe,
  input  logic [7:0]  cart_din
);

  localparam int MAX_SH  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int MAX_CYC = (MAX_SH > STROBE_CYC) ? MAX_SH : STROBE_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          wr;
  logic [7:0]    din_q;

  // Pins are registered and updated on the edge that enters each phase.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      wr        <= 1'b0;
      din_q     <= 8'hFF;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'hFF;
      cart_clk  <= 1'b0;
      cart_rd_n <= 1'b1;
      cart_wr_n <= 1'b1;
      cart_cs_n <= 1'b1;
      cart_addr <= 16'h0000;
      cart_dout <= 8'h00;
      cart_doe  <= 1'b0;
    end else begin
      din_q     <= cart_din;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            state     <= SETUP;
            cnt       <= CW'(SETUP_CYC - 1);
            wr        <= req_wr;
            req_ready <= 1'b0;
            cart_addr <= req_addr;
            cart_cs_n <= ~req_sram;
            if (req_wr) begin
              cart_doe  <= 1'b1;
              cart_dout <= req_wdata;
            end else begin
              cart_rd_n <= 1'b0;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state     <= STROBE;
            cnt       <= CW'(STROBE_CYC - 1);
            cart_clk  <= 1'b1;
            cart_wr_n <= ~wr;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            state     <= HOLD;
            cnt       <= CW'(HOLD_CYC - 1);
            cart_clk  <= 1'b0;
            cart_wr_n <= 1'b1;
            cart_rd_n <= 1'b1;
            // din_q holds the pin value from the second-to-last strobe cycle
            if (!wr) rsp_rdata <= din_q;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state     <= IDLE;
            cart_cs_n <= 1'b1;
            cart_doe  <= 1'b0;
            rsp_valid <= 1'b1;
            req_ready <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gb_cart_bus_cycle.sv
// Bench for gb_cart_bus_cycle: directed transaction table, hand-written corner sequences, then random traffic
// checked every cycle against a timeline model indexed by cycles since acceptance.
`timescale 1ns/1ps
module tb_gb_cart_bus_cycle;
  localparam int S = 2;
  localparam int P = 6;
  localparam int H = 1;
  localparam int N = S + P + H;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic        req_sram;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        cart_clk;
  logic        cart_rd_n;
  logic        cart_wr_n;
  logic        cart_cs_n;
  logic [15:0] cart_addr;
  logic [7:0]  cart_dout;
  logic        cart_doe;
  logic [7:0]  cart_din;

  always #5 clk_sys = ~clk_sys;

  gb_cart_bus_cycle #(.SETUP_CYC(S), .STROBE_CYC(P), .HOLD_CYC(H)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_sram(req_sram),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .cart_clk(cart_clk), .cart_rd_n(cart_rd_n), .cart_wr_n(cart_wr_n), .cart_cs_n(cart_cs_n),
    .cart_addr(cart_addr), .cart_dout(cart_dout), .cart_doe(cart_doe), .cart_din(cart_din)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: k = cycles since the accept edge (0 = no transaction in flight)
  int          k = 0;
  logic        ready_e = 1'b0;
  logic [7:0]  rdata_e = 8'hFF;
  logic [7:0]  cap = 8'hFF;
  logic [15:0] addr_e = 16'h0000;
  logic        t_wr = 1'b0;
  logic        t_sram = 1'b0;
  logic [7:0]  t_wdata = 8'h00;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      k = 0; ready_e = 1'b0; rdata_e = 8'hFF; addr_e = 16'h0000; t_wr = 1'b0; t_sram = 1'b0;
    end else if (k == 0 || k == N + 1) begin
      if (req_valid && ready_e) begin
        k = 1; t_wr = req_wr; t_sram = req_sram; t_wdata = req_wdata; addr_e = req_addr; ready_e = 1'b0;
      end else begin
        k = 0; ready_e = 1'b1;
      end
    end else begin
      if (!t_wr && k == S + P - 1) cap = cart_din;
      if (!t_wr && k == S + P) rdata_e = cap;
      k++;
      if (k == N + 1) ready_e = 1'b1;
    end
  endtask

  task automatic check_model();
    logic busy;
    busy = (k >= 1 && k <= N);
    chk1("m_ready", req_ready, ready_e);
    chk1("m_rsp_valid", rsp_valid, k == N + 1);
    chk8("m_rsp_rdata", rsp_rdata, rdata_e);
    chk1("m_cart_clk", cart_clk, k >= S + 1 && k <= S + P);
    chk1("m_rd_n", cart_rd_n, !(busy && !t_wr && k <= S + P));
    chk1("m_wr_n", cart_wr_n, !(busy && t_wr && k >= S + 1 && k <= S + P));
    chk1("m_cs_n", cart_cs_n, !(busy && t_sram));
    chk1("m_doe", cart_doe, busy && t_wr);
    chk16("m_addr", cart_addr, addr_e);
    chk1("m_rd_wr_excl", cart_rd_n | cart_wr_n, 1'b1);
    if (busy && t_wr) chk8("m_dout", cart_dout, t_wdata);
  endtask

  task automatic cycle();
    @(posedge clk_sys);
    model_edge();
    @(negedge clk_sys);
    cyc++;
    check_model();
  endtask

  task automatic issue(input logic wr, input logic sram, input logic [15:0] addr, input logic [7:0] wd,
                       output logic acc);
    req_wr = wr; req_sram = sram; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      if (req_ready) acc = 1'b1;
      cycle();
    end
    req_valid = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic        sram;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  din;
    logic [7:0]  rdata;
    int          rd_lo, wr_lo, clk_hi, clk_first, cs_lo, doe_hi, lat;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int rd_lo = 0, wr_lo = 0, clk_hi = 0, clk_first = -1, cs_lo = 0, doe_hi = 0;
    int lat = -1, rsp_n = 0, dout_bad = 0, addr_bad = 0;
    logic acc;
    cart_din = v.din;
    issue(v.wr, v.sram, v.addr, v.wdata, acc);
    chk1("t_accept", acc, 1'b1);
    for (int kk = 1; kk <= 12; kk++) begin
      if (!cart_rd_n) rd_lo++;
      if (!cart_wr_n) wr_lo++;
      if (cart_clk) begin
        clk_hi++;
        if (clk_first < 0) clk_first = kk;
      end
      if (!cart_cs_n) cs_lo++;
      if (cart_doe) begin
        doe_hi++;
        if (cart_dout !== v.wdata) dout_bad++;
      end
      if (rsp_valid) begin
        rsp_n++;
        if (lat < 0) lat = kk;
      end
      if (kk <= N && cart_addr !== v.addr) addr_bad++;
      cycle();
    end
    chki("t_rd_low_cycles", rd_lo, v.rd_lo);
    chki("t_wr_low_cycles", wr_lo, v.wr_lo);
    chki("t_clk_high_cycles", clk_hi, v.clk_hi);
    chki("t_clk_first", clk_first, v.clk_first);
    chki("t_cs_low_cycles", cs_lo, v.cs_lo);
    chki("t_doe_cycles", doe_hi, v.doe_hi);
    chki("t_latency", lat, v.lat);
    chki("t_rsp_pulses", rsp_n, 1);
    chki("t_dout_bad", dout_bad, 0);
    chki("t_addr_bad", addr_bad, 0);
    chk8("t_rdata", rsp_rdata, v.rdata);
  endtask

  vec_t vt[4];

  initial begin
    logic acc;
    logic seen;
    int   cnt;

    vt[0] = '{1'b0, 1'b0, 16'h4123, 8'h00, 8'h5A, 8'h5A, 8, 0, 6, 3, 0, 0, 10};
    vt[1] = '{1'b1, 1'b0, 16'h2000, 8'h03, 8'hE7, 8'h5A, 0, 6, 6, 3, 0, 9, 10};
    vt[2] = '{1'b0, 1'b1, 16'hA010, 8'h00, 8'hC3, 8'hC3, 8, 0, 6, 3, 9, 0, 10};
    vt[3] = '{1'b1, 1'b1, 16'hA011, 8'h77, 8'h18, 8'hC3, 0, 6, 6, 3, 9, 9, 10};

    reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_sram = 1'b0;
    req_addr = 16'h0000; req_wdata = 8'h00; cart_din = 8'h00;

    for (int i = 0; i < 3; i++) begin
      cycle();
      chk1("rst_ready", req_ready, 1'b0);
    end
    chk8("rst_dout", cart_dout, 8'h00);
    chk8("rst_rdata", rsp_rdata, 8'hFF);
    chk16("rst_addr", cart_addr, 16'h0000);
    reset = 1'b0;
    cycle();
    chk1("rel_ready", req_ready, 1'b1);

    for (int i = 0; i < 4; i++) run_vec(vt[i]);

    // Back-to-back: new write accepted on the completion cycle of an SRAM read
    cart_din = 8'h3C;
    issue(1'b0, 1'b1, 16'hA020, 8'h00, acc);
    seen = 1'b0;
    for (int i = 0; i < 15 && !seen; i++) begin
      if (rsp_valid) seen = 1'b1;
      else cycle();
    end
    chk1("b2b_rsp_seen", seen, 1'b1);
    chk1("b2b_ready", req_ready, 1'b1);
    req_wr = 1'b1; req_sram = 1'b0; req_addr = 16'h3000; req_wdata = 8'h9A; req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    chk1("b2b_setup_doe", cart_doe, 1'b1);
    chk16("b2b_setup_addr", cart_addr, 16'h3000);
    chk8("b2b_rdata", rsp_rdata, 8'h3C);
    for (int i = 0; i < 12; i++) cycle();

    // Request pulse while busy must be ignored
    cart_din = 8'h11;
    issue(1'b0, 1'b0, 16'h1234, 8'h00, acc);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (cart_clk) seen = 1'b1;
      else cycle();
    end
    chk1("ign_in_strobe", seen, 1'b1);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h5555;
    cycle();
    req_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 6) chk16("ign_addr", cart_addr, 16'h1234);
      if (rsp_valid) cnt++;
      cycle();
    end
    chki("ign_rsp_pulses", cnt, 1);
    chk8("ign_rdata", rsp_rdata, 8'h11);

    // Reset during the strobe of an SRAM write
    issue(1'b1, 1'b1, 16'hA100, 8'h55, acc);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (!cart_wr_n) seen = 1'b1;
      else cycle();
    end
    chk1("abort_in_strobe", seen, 1'b1);
    reset = 1'b1;
    cycle();
    chk1("abort_wr_n", cart_wr_n, 1'b1);
    chk1("abort_doe", cart_doe, 1'b0);
    chk1("abort_cs_n", cart_cs_n, 1'b1);
    chk1("abort_clk", cart_clk, 1'b0);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (rsp_valid) cnt++;
      cycle();
    end
    chki("abort_rsp_pulses", cnt, 0);

    // Random traffic against the timeline model
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 299) == 0);
      req_valid = ($urandom_range(0, 2) != 0);
      req_wr    = 1'($urandom_range(0, 1));
      req_sram  = 1'($urandom_range(0, 1));
      req_addr  = 16'($urandom);
      req_wdata = 8'($urandom);
      cart_din  = 8'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
